y_writeback: RTL and testbench
==============================

Y_WRITEBACK -- requirements
Module: y_writeback

Interface
- REQ-001 SHALL have parameter M, default 12, output rows per tile (IMG_H*IMG_W).
- REQ-002 SHALL have parameter K, default 5, filters per row (FILTER_NUM).
- REQ-003 SHALL have parameter DATA_WIDTH, default 32, word width.
- REQ-004 SHALL have parameter ADDR_WIDTH, default 32, memory address width.
- REQ-005 SHALL have parameter OUTPUT_BASE, default 32'h00003000, first output word address.
- REQ-006 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
- REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
- REQ-008 SHALL have port Y, input, DATA_WIDTH*K, one systolic output row; filter i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- REQ-009 SHALL have port valid, input, 1, Y holds a valid row this cycle.
- REQ-010 SHALL have port addr_wr, output, ADDR_WIDTH, memory write address.
- REQ-011 SHALL have port data_wr, output, DATA_WIDTH, memory write data.
- REQ-012 SHALL have port mem_wr_en, output, 1, memory write strobe.
- REQ-013 SHALL have port done, output, 1, all K*M words written.

Function
- REQ-014 SHALL implement states CAPTURE, WRITE, DONE; CAPTURE is the state after reset.
- REQ-015 CAPTURE: each edge with valid=1 SHALL store Y into row buffer entry row_cnt and increment row_cnt; edges with valid=0 store nothing, count holds (gaps allowed).
- REQ-016 On the edge capturing row M-1 the block SHALL enter WRITE; no row beyond M is stored.
- REQ-017 WRITE: one word per cycle, filter index i outer (0..K-1), row index j inner (0..M-1); addr_wr = OUTPUT_BASE + i*M + j, data_wr = buffer[j] filter i, mem_wr_en=1.
- REQ-018 First write (i=0,j=0) SHALL be presented the cycle after the final capture edge; outputs registered; write phase lasts exactly K*M consecutive cycles.
- REQ-019 After the write at i=K-1,j=M-1, the block SHALL enter DONE next edge: mem_wr_en=0, done=1, held until rst.
- REQ-020 valid and Y SHALL be ignored in WRITE and DONE.
- REQ-021 Index arithmetic SHALL be unsigned, counters sized clog2 of their bound (minimum 1 bit), addresses computed at ADDR_WIDTH with wrap modulo 2^ADDR_WIDTH.
- REQ-022 mem_wr_en SHALL never be 1 outside WRITE; addr_wr/data_wr are don't-care when mem_wr_en=0 but SHALL not be X after reset.

Reset
- REQ-023 rst=1 SHALL asynchronously force state CAPTURE, row_cnt=0, write indices 0, mem_wr_en=0, done=0, addr_wr=0, data_wr=0.
- REQ-024 rst asserted mid-CAPTURE or mid-WRITE SHALL abort; remaining writes are not issued; buffer contents need not be cleared.
- REQ-025 Capture SHALL resume on the first edge after rst deasserts where valid=1.

Configuration
- REQ-026 Macro Y_WRITEBACK_RELU_EN defined: data_wr SHALL be 0 when the selected word is negative (two's complement MSB=1), else unchanged; same timing.
- REQ-027 Macro undefined: data_wr SHALL be the raw buffer word.

Structure
- REQ-028 Shared package SHALL hold state encoding and default constants (OUTPUT_BASE, DATA_WIDTH, ADDR_WIDTH).
- REQ-029 Row buffer SHALL be sub-module y_row_buffer (M entries x DATA_WIDTH*K, one write port, one combinational read port with word select).

Verification
- REQ-030 Defaults, valid high 12 cycles, row j filter i = 16'h0100*i + j -> 60 writes, addr 0x3000..0x303B, word at 0x3000+12*i+j = 0x100*i+j, done at cycle 61 after first write.
- REQ-031 valid pattern 1,0,0,1,... with 12 valid cycles -> identical write sequence as REQ-030; first write one cycle after 12th valid edge.
- REQ-032 rst pulse after 30 writes -> mem_wr_en=0 and done=0 immediately; new 12-row tile then writes all 60 words from 0x3000.
- REQ-033 valid held high 20 cycles -> rows 12..19 ignored; written data equals rows 0..11 only.
- REQ-034 Y_WRITEBACK_RELU_EN defined, row 0 filter 0 = 32'hFFFFFFF6 (-10), filter 1 = 7 -> 0x3000 receives 0, 0x300C receives 7; undefined -> 0x3000 receives 32'hFFFFFFF6.
- REQ-035 M=1,K=1 -> single write to OUTPUT_BASE, done next cycle.

Source files
------------

// File: rtl/y_writeback_pkg.sv
// Shared constants for the y_writeback output stage.
// State encoding, default widths/base address and an index-width helper.
package y_writeback_pkg;

  localparam logic [1:0] ST_CAPTURE = 2'd0;
  localparam logic [1:0] ST_WRITE   = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam logic [31:0] DEF_OUTPUT_BASE = 32'h0000_3000;

  // Counter width for a bound, never below one bit.
  function automatic int idx_width(input int bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

endpackage

// File: rtl/y_row_buffer.sv
// Row buffer holding M systolic output rows of K words each.
// One synchronous write port, one combinational word-select read port.
module y_row_buffer
  import y_writeback_pkg::*;
#(
  parameter int M          = 12,
  parameter int K          = 5,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int RW        = idx_width(M),
  localparam int KW        = idx_width(K)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [RW-1:0]           waddr,
  input  logic [DATA_WIDTH*K-1:0] wdata,
  input  logic [RW-1:0]           raddr,
  input  logic [KW-1:0]           rsel,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [K-1:0][DATA_WIDTH-1:0] mem [M];

  // Store a whole row; contents need no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr][rsel];

endmodule

// File: rtl/y_writeback.sv
// Captures M output rows, then writes them filter-major to memory.
// Define Y_WRITEBACK_RELU_EN to clamp negative words to zero on write.
module y_writeback
  import y_writeback_pkg::*;
#(
  parameter int M          = 12,
  parameter int K          = 5,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE =
    ADDR_WIDTH'(DEF_OUTPUT_BASE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH*K-1:0] Y,
  input  logic                    valid,
  output logic [ADDR_WIDTH-1:0]   addr_wr,
  output logic [DATA_WIDTH-1:0]   data_wr,
  output logic                    mem_wr_en,
  output logic                    done
);

  localparam int RW = idx_width(M);
  localparam int KW = idx_width(K);
  localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);
  localparam logic [KW-1:0] FLT_LAST = KW'(K - 1);

  logic [1:0]            state;
  logic [RW-1:0]         row_cnt;
  logic [RW-1:0]         cur_j;
  logic [RW-1:0]         nxt_j;
  logic [KW-1:0]         cur_i;
  logic [KW-1:0]         nxt_i;
  logic                  buf_we;
  logic                  wr_last;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] src_word;
  logic [DATA_WIDTH-1:0] out_word;
  logic [ADDR_WIDTH-1:0] nxt_addr;

  assign buf_we  = (state == ST_CAPTURE) && valid;
  assign wr_last = (cur_i == FLT_LAST) && (cur_j == ROW_LAST);

  y_row_buffer #(
    .M          (M),
    .K          (K),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (row_cnt),
    .wdata (Y),
    .raddr (nxt_j),
    .rsel  (nxt_i),
    .rdata (rd_word)
  );

  // Index of the word to register next; restarts at 0 outside WRITE.
  always_comb begin
    nxt_i = cur_i;
    nxt_j = cur_j + RW'(1);
    if (state != ST_WRITE) begin
      nxt_i = '0;
      nxt_j = '0;
    end else if (cur_j == ROW_LAST) begin
      nxt_i = cur_i + KW'(1);
      nxt_j = '0;
    end
  end

  // Single-row tiles: row 0 is still being stored, so bypass the buffer.
  always_comb begin
    src_word = rd_word;
    if (M == 1 && state == ST_CAPTURE) begin
      src_word = Y[DATA_WIDTH-1:0];
    end
`ifdef Y_WRITEBACK_RELU_EN
    out_word = src_word[DATA_WIDTH-1] ? '0 : src_word;
`else
    out_word = src_word;
`endif
    nxt_addr = OUTPUT_BASE
             + ADDR_WIDTH'(nxt_i) * ADDR_WIDTH'(M)
             + ADDR_WIDTH'(nxt_j);
  end

  // Capture rows, then stream one registered write per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_CAPTURE;
      row_cnt   <= '0;
      cur_i     <= '0;
      cur_j     <= '0;
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
      addr_wr   <= '0;
      data_wr   <= '0;
    end else begin
      case (state)
        ST_CAPTURE: begin
          if (valid) begin
            if (row_cnt == ROW_LAST) begin
              row_cnt   <= '0;
              state     <= ST_WRITE;
              cur_i     <= '0;
              cur_j     <= '0;
              mem_wr_en <= 1'b1;
              addr_wr   <= nxt_addr;
              data_wr   <= out_word;
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end
        ST_WRITE: begin
          if (wr_last) begin
            state     <= ST_DONE;
            mem_wr_en <= 1'b0;
            done      <= 1'b1;
          end else begin
            cur_i   <= nxt_i;
            cur_j   <= nxt_j;
            addr_wr <= nxt_addr;
            data_wr <= out_word;
          end
        end
        ST_DONE: begin
          mem_wr_en <= 1'b0;
          done      <= 1'b1;
        end
        default: begin
          state     <= ST_CAPTURE;
          mem_wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y_writeback.sv
// Scoreboard bench for y_writeback (default 12x5 and a 1x1 instance).
// Expected writes are queued by stimulus and popped by a monitor.
module tb_y_writeback;

  localparam int M  = 12;
  localparam int K  = 5;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW*K-1:0] y;
  logic          valid;
  logic [AW-1:0] addr_wr;
  logic [DW-1:0] data_wr;
  logic          mem_wr_en;
  logic          done;

  logic [DW-1:0] y1;
  logic          valid1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] data1;
  logic          en1;
  logic          done1;

  int vecs = 0;
  int errs = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  y_writeback #(.M(M), .K(K)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .Y         (y),
    .valid     (valid),
    .addr_wr   (addr_wr),
    .data_wr   (data_wr),
    .mem_wr_en (mem_wr_en),
    .done      (done)
  );

  y_writeback #(.M(1), .K(1)) u_one (
    .clk       (clk),
    .rst       (rst),
    .Y         (y1),
    .valid     (valid1),
    .addr_wr   (addr1),
    .data_wr   (data1),
    .mem_wr_en (en1),
    .done      (done1)
  );

  function automatic logic [31:0] yword(input int t, input int i,
                                        input int j);
    logic [31:0] base;
    base = 32'(32'h100 * i + j);
    case (t)
      0: return base;
      1: return 32'hA000_0000 | base;
      2: begin
        if (i == 0 && j == 0) return 32'hFFFF_FFF6;
        if (i == 1 && j == 0) return 32'h0000_0007;
        return base;
      end
      default: return 32'hDEAD_0000 | base;
    endcase
  endfunction

  function automatic logic [31:0] relu(input logic [31:0] w);
`ifdef Y_WRITEBACK_RELU_EN
    return w[31] ? 32'h0 : w;
`else
    return w;
`endif
  endfunction

  function automatic logic [DW*K-1:0] row_of(input int t, input int j);
    logic [DW*K-1:0] r;
    r = '0;
    for (int i = 0; i < K; i++) r[i*DW +: DW] = yword(t, i, j);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_tile(input int t);
    logic [31:0] a;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < M; j++) begin
        a = 32'(32'h3000 + i * M + j);
        sb.push_back({a, relu(yword(t, i, j))});
      end
    end
  endtask

  task automatic apply(input logic v, input logic [DW*K-1:0] r);
    valid = v;
    y     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 64'(done), 64'd1);
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every presented write must match the head of the queue.
  always @(negedge clk) begin
    if (rst === 1'b0 && mem_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_write: got %h/%h expected none",
                 addr_wr, data_wr);
      end else begin
        check("write", {addr_wr, data_wr}, sb.pop_front());
      end
    end
  end

  initial begin
    rst    = 1'b1;
    valid  = 1'b0;
    y      = '0;
    valid1 = 1'b0;
    y1     = '0;
    @(posedge clk);
    #1;
    check("rst_en",   64'(mem_wr_en), 64'd0);
    check("rst_done", 64'(done),      64'd0);
    check("rst_addr", 64'(addr_wr),   64'd0);
    check("rst_data", 64'(data_wr),   64'd0);
    check("rst_en1",  64'(en1),       64'd0);
    rst = 1'b0;

    // Back-to-back rows, exact write/done timing.
    push_tile(0);
    for (int j = 0; j < M; j++) apply(1'b1, row_of(0, j));
    check("A_first_write", 64'(mem_wr_en), 64'd1);
    repeat (K * M - 1) @(posedge clk);
    #1;
    check("A_last_en",   64'(mem_wr_en), 64'd1);
    check("A_last_done", 64'(done),      64'd0);
    @(posedge clk);
    #1;
    check("A_done",    64'(done),      64'd1);
    check("A_done_en", 64'(mem_wr_en), 64'd0);
    check("A_sb_empty", 64'(sb.size()), 64'd0);
    for (int n = 0; n < 3; n++) apply(1'b1, row_of(3, n));
    check("A_done_held", 64'(done), 64'd1);

    // Gapped valid pattern 1,0,0.
    do_reset();
    push_tile(0);
    for (int j = 0; j < M; j++) begin
      apply(1'b1, row_of(0, j));
      if (j < M - 1) begin
        apply(1'b0, row_of(3, j));
        apply(1'b0, row_of(3, j));
      end
    end
    check("B_first_write", 64'(mem_wr_en), 64'd1);
    valid = 1'b0;
    wait_done("B_done", 80);

    // Reset after 30 writes aborts, next tile restarts at base.
    do_reset();
    push_tile(1);
    for (int j = 0; j < M; j++) apply(1'b1, row_of(1, j));
    valid = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("C_rst_en",   64'(mem_wr_en), 64'd0);
    check("C_rst_done", 64'(done),      64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(1'b0, row_of(3, 0));
    apply(1'b0, row_of(3, 1));
    check("C_idle_en", 64'(mem_wr_en), 64'd0);
    push_tile(0);
    for (int j = 0; j < M; j++) apply(1'b1, row_of(0, j));
    valid = 1'b0;
    wait_done("C_done", 80);

    // valid held for 20 rows; extra rows must be ignored.
    do_reset();
    push_tile(0);
    for (int j = 0; j < 20; j++)
      apply(1'b1, row_of((j < M) ? 0 : 3, j));
    valid = 1'b0;
    wait_done("D_done", 80);

    // Negative and positive words (ReLU-dependent).
    do_reset();
    push_tile(2);
    for (int j = 0; j < M; j++) apply(1'b1, row_of(2, j));
    valid = 1'b0;
    wait_done("E_done", 80);

    // Single-word tile.
    do_reset();
    y1     = 32'h8000_0005;
    valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    check("F_en1",   64'(en1),   64'd1);
    check("F_addr1", 64'(addr1), 64'h3000);
    check("F_data1", 64'(data1), 64'(relu(32'h8000_0005)));
    check("F_done1_low", 64'(done1), 64'd0);
    @(posedge clk);
    #1;
    check("F_done1",  64'(done1), 64'd1);
    check("F_en1_off", 64'(en1),  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
